// File: rtl/dm_arb_pkg.sv
// Shared definitions for the debug/core system-bus arbiter.
// Holds the arbiter state encoding, the master index constants and the
// width of the optional fairness counter (built only with DM_ARB_FAIR_EN).
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  localparam logic ARB_M_CORE = 1'b0;
  localparam logic ARB_M_DBG  = 1'b1;

  localparam int unsigned ARB_CNT_W = 4;

endpackage

// File: rtl/dm_arb_fair_cnt.sv
// Fairness counter for dm_bus_arbiter (instantiated only with DM_ARB_FAIR_EN).
// Counts debug grants taken while the core is waiting and unlocked, saturates
// at its maximum, and asks the arbiter to favour the core once the count
// reaches MAX_DBG_BURST.
module dm_arb_fair_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_DBG_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_grant_i,
  input  logic m1_grant_i,
  input  logic m0_valid_i,
  input  logic dbg_lock_i,
  output logic force_m0_o
);

  localparam logic [ARB_CNT_W-1:0] CNT_MAX   = {ARB_CNT_W{1'b1}};
  localparam logic [ARB_CNT_W-1:0] CNT_LIMIT = ARB_CNT_W'(MAX_DBG_BURST);

  logic [ARB_CNT_W-1:0] cnt_d, cnt_q;

  // Next count: a core grant clears, a debug grant counts only while the core waits unlocked.
  always_comb begin
    cnt_d = cnt_q;
    if (m0_grant_i) begin
      cnt_d = '0;
    end else if (m1_grant_i) begin
      if (m0_valid_i && !dbg_lock_i) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (!m0_valid_i) begin
        cnt_d = '0;
      end
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_m0_o = (cnt_q == CNT_LIMIT) && m0_valid_i && !dbg_lock_i;

endmodule

// File: rtl/dm_bus_arbiter.sv
// Two-master, one-slave system bus arbiter: core load/store port (m0) and
// debug module system-bus port (m1). One outstanding transaction at a time;
// the response is routed back to the master that issued it. Debug has
// priority; while dbg_lock_i is high the core is never granted.
// Optional build macro DM_ARB_FAIR_EN adds a fairness counter that forces a
// core grant after MAX_DBG_BURST consecutive debug grants while the core waits.
module dm_bus_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_DBG_BURST = 4,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dbg_lock_i,
  input  logic                m0_req_valid_i,
  output logic                m0_req_ready_o,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic                m0_rsp_valid_o,
  input  logic                m0_rsp_ready_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_valid_i,
  output logic                m1_req_ready_o,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic                m1_rsp_valid_o,
  input  logic                m1_rsp_ready_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_req_valid_o,
  input  logic                s_req_ready_i,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  input  logic                s_rsp_valid_i,
  output logic                s_rsp_ready_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  output logic                owner_o,
  output logic                busy_o
);

  arb_state_e          state_d, state_q;
  logic                owner_d, owner_q;
  logic                s_we_d, s_we_q;
  logic [ADDR_W-1:0]   s_addr_d, s_addr_q;
  logic [DATA_W-1:0]   s_wdata_d, s_wdata_q;
  logic [DATA_W/8-1:0] s_sel_d, s_sel_q;
  logic                gnt_m0, gnt_m1;
  logic                force_m0;
  logic                rsp_ready_sel;

`ifdef DM_ARB_FAIR_EN
  dm_arb_fair_cnt #(
    .MAX_DBG_BURST(MAX_DBG_BURST)
  ) u_fair_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_grant_i (gnt_m0),
    .m1_grant_i (gnt_m1),
    .m0_valid_i (m0_req_valid_i),
    .dbg_lock_i (dbg_lock_i),
    .force_m0_o (force_m0)
  );
`else
  logic unused_max_burst;
  assign unused_max_burst = ^MAX_DBG_BURST;
  assign force_m0         = 1'b0;
`endif

  // Arbitration, payload capture, response routing and next-state selection.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    s_we_d         = s_we_q;
    s_addr_d       = s_addr_q;
    s_wdata_d      = s_wdata_q;
    s_sel_d        = s_sel_q;
    gnt_m0         = 1'b0;
    gnt_m1         = 1'b0;
    rsp_ready_sel  = 1'b0;
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    m0_rsp_valid_o = 1'b0;
    m1_rsp_valid_o = 1'b0;
    s_req_valid_o  = 1'b0;
    s_rsp_ready_o  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        gnt_m1         = m1_req_valid_i && !force_m0;
        gnt_m0         = m0_req_valid_i && !dbg_lock_i && (!m1_req_valid_i || force_m0);
        m0_req_ready_o = gnt_m0;
        m1_req_ready_o = gnt_m1;
        if (gnt_m1) begin
          owner_d   = ARB_M_DBG;
          s_we_d    = m1_we_i;
          s_addr_d  = m1_addr_i;
          s_wdata_d = m1_wdata_i;
          s_sel_d   = m1_sel_i;
          state_d   = ARB_REQ;
        end else if (gnt_m0) begin
          owner_d   = ARB_M_CORE;
          s_we_d    = m0_we_i;
          s_addr_d  = m0_addr_i;
          s_wdata_d = m0_wdata_i;
          s_sel_d   = m0_sel_i;
          state_d   = ARB_REQ;
        end
      end
      ARB_REQ: begin
        s_req_valid_o = 1'b1;
        if (s_req_ready_i) begin
          state_d = ARB_RSP;
        end
      end
      ARB_RSP: begin
        if (owner_q == ARB_M_DBG) begin
          rsp_ready_sel  = m1_rsp_ready_i;
          m1_rsp_valid_o = s_rsp_valid_i;
        end else begin
          rsp_ready_sel  = m0_rsp_ready_i;
          m0_rsp_valid_o = s_rsp_valid_i;
        end
        s_rsp_ready_o = rsp_ready_sel;
        if (s_rsp_valid_i && rsp_ready_sel) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, owner and registered slave payload with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= ARB_M_CORE;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_sel_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_sel_q   <= s_sel_d;
    end
  end

  assign s_we_o     = s_we_q;
  assign s_addr_o   = s_addr_q;
  assign s_wdata_o  = s_wdata_q;
  assign s_sel_o    = s_sel_q;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q != ARB_IDLE);
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed self-checking bench for dm_bus_arbiter.
// Expected grant order depends on DM_ARB_FAIR_EN (fairness with burst 4, or
// strict debug priority when the macro is undefined).
module tb_dm_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

`ifdef DM_ARB_FAIR_EN
  localparam logic [9:0] EXP_M1_GRANTS = 10'b0111101111;
`else
  localparam logic [9:0] EXP_M1_GRANTS = 10'b1111111111;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dbg_lock_i = 1'b0;
  logic                m0_req_valid_i = 1'b0;
  logic                m0_req_ready_o;
  logic                m0_we_i = 1'b0;
  logic [ADDR_W-1:0]   m0_addr_i = '0;
  logic [DATA_W-1:0]   m0_wdata_i = '0;
  logic [DATA_W/8-1:0] m0_sel_i = '0;
  logic                m0_rsp_valid_o;
  logic                m0_rsp_ready_i = 1'b0;
  logic [DATA_W-1:0]   m0_rdata_o;
  logic                m1_req_valid_i = 1'b0;
  logic                m1_req_ready_o;
  logic                m1_we_i = 1'b0;
  logic [ADDR_W-1:0]   m1_addr_i = '0;
  logic [DATA_W-1:0]   m1_wdata_i = '0;
  logic [DATA_W/8-1:0] m1_sel_i = '0;
  logic                m1_rsp_valid_o;
  logic                m1_rsp_ready_i = 1'b0;
  logic [DATA_W-1:0]   m1_rdata_o;
  logic                s_req_valid_o;
  logic                s_req_ready_i = 1'b0;
  logic                s_we_o;
  logic [ADDR_W-1:0]   s_addr_o;
  logic [DATA_W-1:0]   s_wdata_o;
  logic [DATA_W/8-1:0] s_sel_o;
  logic                s_rsp_valid_i = 1'b0;
  logic                s_rsp_ready_o;
  logic [DATA_W-1:0]   s_rdata_i = '0;
  logic                owner_o;
  logic                busy_o;

  int checks = 0;
  int errors = 0;

  dm_bus_arbiter #(
    .MAX_DBG_BURST(4),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dbg_lock_i     (dbg_lock_i),
    .m0_req_valid_i (m0_req_valid_i),
    .m0_req_ready_o (m0_req_ready_o),
    .m0_we_i        (m0_we_i),
    .m0_addr_i      (m0_addr_i),
    .m0_wdata_i     (m0_wdata_i),
    .m0_sel_i       (m0_sel_i),
    .m0_rsp_valid_o (m0_rsp_valid_o),
    .m0_rsp_ready_i (m0_rsp_ready_i),
    .m0_rdata_o     (m0_rdata_o),
    .m1_req_valid_i (m1_req_valid_i),
    .m1_req_ready_o (m1_req_ready_o),
    .m1_we_i        (m1_we_i),
    .m1_addr_i      (m1_addr_i),
    .m1_wdata_i     (m1_wdata_i),
    .m1_sel_i       (m1_sel_i),
    .m1_rsp_valid_o (m1_rsp_valid_o),
    .m1_rsp_ready_i (m1_rsp_ready_i),
    .m1_rdata_o     (m1_rdata_o),
    .s_req_valid_o  (s_req_valid_o),
    .s_req_ready_i  (s_req_ready_i),
    .s_we_o         (s_we_o),
    .s_addr_o       (s_addr_o),
    .s_wdata_o      (s_wdata_o),
    .s_sel_o        (s_sel_o),
    .s_rsp_valid_i  (s_rsp_valid_i),
    .s_rsp_ready_o  (s_rsp_ready_o),
    .s_rdata_i      (s_rdata_i),
    .owner_o        (owner_o),
    .busy_o         (busy_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic master, input logic valid, input logic we,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                               input logic [DATA_W/8-1:0] sel);
    if (master) begin
      m1_req_valid_i = valid;
      m1_we_i        = we;
      m1_addr_i      = addr;
      m1_wdata_i     = wdata;
      m1_sel_i       = sel;
    end else begin
      m0_req_valid_i = valid;
      m0_we_i        = we;
      m0_addr_i      = addr;
      m0_wdata_i     = wdata;
      m0_sel_i       = sel;
    end
  endtask

  initial begin
    $display("[TB] starting dm_bus_arbiter bench");

    // Reset: idle outputs
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    checkOutput("rst_m0_req_ready", m0_req_ready_o, 0);
    checkOutput("rst_m1_req_ready", m1_req_ready_o, 0);
    checkOutput("rst_m0_rsp_valid", m0_rsp_valid_o, 0);
    checkOutput("rst_m1_rsp_valid", m1_rsp_valid_o, 0);
    checkOutput("rst_s_req_valid", s_req_valid_o, 0);
    checkOutput("rst_s_rsp_ready", s_rsp_ready_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_owner", owner_o, 0);
    checkOutput("rst_s_addr", s_addr_o, 0);

    // Core read against a zero-wait slave
    s_req_ready_i  = 1'b1;
    s_rsp_valid_i  = 1'b1;
    s_rdata_i      = 32'hDEAD_BEEF;
    m0_rsp_ready_i = 1'b1;
    m1_rsp_ready_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    settle();
    checkOutput("rd_accept", m0_req_ready_o, 1);
    tick();
    checkOutput("rd_s_req_valid", s_req_valid_o, 1);
    checkOutput("rd_s_addr", s_addr_o, 32'h8000_0010);
    checkOutput("rd_s_we", s_we_o, 0);
    checkOutput("rd_owner", owner_o, 0);
    checkOutput("rd_busy", busy_o, 1);
    checkOutput("rd_no_ready_in_req", m0_req_ready_o, 0);
    tick();
    checkOutput("rd_m0_rsp_valid", m0_rsp_valid_o, 1);
    checkOutput("rd_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    checkOutput("rd_m1_rsp_valid", m1_rsp_valid_o, 0);
    checkOutput("rd_s_rsp_ready", s_rsp_ready_o, 1);
    tick();
    checkOutput("rd_next_accept", m0_req_ready_o, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("rd_back_idle", busy_o, 0);

    // Both masters requesting every cycle: grant order
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      settle();
      checkOutput($sformatf("grant%0d_m1", i), m1_req_ready_o, EXP_M1_GRANTS[i]);
      checkOutput($sformatf("grant%0d_m0", i), m0_req_ready_o, !EXP_M1_GRANTS[i]);
      tick();
      tick();
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    checkOutput("grant_end_idle", busy_o, 0);

    // Lock holds off the core, release lets it in at once
    dbg_lock_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      settle();
      checkOutput($sformatf("lock%0d_m0_ready", i), m0_req_ready_o, 0);
      tick();
    end
    checkOutput("lock_still_idle", busy_o, 0);
    dbg_lock_i = 1'b0;
    settle();
    checkOutput("unlock_accept", m0_req_ready_o, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("unlock_s_addr", s_addr_o, 32'h0000_0300);
    checkOutput("unlock_owner", owner_o, 0);
    tick();
    tick();
    checkOutput("unlock_done", busy_o, 0);

    // Lock rises while a core write waits in RSP
    m0_rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 4'b1111);
    settle();
    checkOutput("wr_accept", m0_req_ready_o, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("wr_s_we", s_we_o, 1);
    checkOutput("wr_s_wdata", s_wdata_o, 32'h1234_5678);
    checkOutput("wr_s_sel", s_sel_o, 4'b1111);
    tick();
    dbg_lock_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      settle();
      checkOutput($sformatf("wr_hold%0d_m0_rsp", i), m0_rsp_valid_o, 1);
      checkOutput($sformatf("wr_hold%0d_s_rsp_ready", i), s_rsp_ready_o, 0);
      checkOutput($sformatf("wr_hold%0d_m1_rsp", i), m1_rsp_valid_o, 0);
      checkOutput($sformatf("wr_hold%0d_m1_ready", i), m1_req_ready_o, 0);
      tick();
    end
    m0_rsp_ready_i = 1'b1;
    settle();
    checkOutput("wr_release_s_rsp_ready", s_rsp_ready_o, 1);
    checkOutput("wr_release_m0_rsp", m0_rsp_valid_o, 1);
    tick();
    checkOutput("wr_after_m0_rsp", m0_rsp_valid_o, 0);
    checkOutput("wr_after_m1_grant", m1_req_ready_o, 1);
    checkOutput("wr_after_m0_ready", m0_req_ready_o, 0);
    checkOutput("wr_after_owner", owner_o, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dbg_lock_i = 1'b0;
    checkOutput("dbg_owner", owner_o, 1);
    checkOutput("dbg_s_addr", s_addr_o, 32'h0000_0500);
    tick();
    checkOutput("dbg_m1_rsp", m1_rsp_valid_o, 1);
    checkOutput("dbg_m0_rsp", m0_rsp_valid_o, 0);
    tick();
    checkOutput("dbg_done", busy_o, 0);

    // Reset while in REQ with a stalled slave
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    s_req_ready_i = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("rq_s_req_valid", s_req_valid_o, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    s_rsp_valid_i = 1'b1;
    settle();
    checkOutput("rq_rst_s_req_valid", s_req_valid_o, 0);
    checkOutput("rq_rst_busy", busy_o, 0);
    checkOutput("rq_rst_s_addr", s_addr_o, 0);
    checkOutput("rq_stale_m0_rsp", m0_rsp_valid_o, 0);
    checkOutput("rq_stale_m1_rsp", m1_rsp_valid_o, 0);
    tick();
    s_rsp_valid_i = 1'b0;
    checkOutput("rq_stays_idle", busy_o, 0);
    checkOutput("rq_stale_m0_rsp2", m0_rsp_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
